i2s_rx: RTL and testbench



---
 rtl/i2s_rx.sv | 143 ++++++++++++++
 tb/tb_i2s_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bck/lrck/data in the clk domain and assembles
// MSB-first words into left/right sample pairs with a one-cycle valid strobe.
module i2s_rx #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2s_bck,
  input  logic              i2s_lrck,
  input  logic              i2s_data,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              slot_err,
  output logic              locked
);

  logic bck_s1_q, bck_s1_d, bck_s2_q, bck_s2_d, bck_s3_q, bck_s3_d;
  logic lrck_s1_q, lrck_s1_d, lrck_s2_q, lrck_s2_d;
  logic data_s1_q, data_s1_d, data_s2_q, data_s2_d;

  logic              lr_last_q, lr_last_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              have_left_q, have_left_d;
  logic              locked_q, locked_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic [DATA_W-1:0] left_data_q, left_data_d;
  logic [DATA_W-1:0] right_data_q, right_data_d;
  logic              sample_valid_q, sample_valid_d;
  logic              slot_err_q, slot_err_d;

  logic              bck_rise;
  logic [DATA_W-1:0] word_next;
  logic [CNT_W-1:0]  bit_cnt_inc;
  logic              short_slot;

  assign bck_rise = bck_s2_q & ~bck_s3_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    bck_s1_d       = i2s_bck;
    bck_s2_d       = bck_s1_q;
    bck_s3_d       = bck_s2_q;
    lrck_s1_d      = i2s_lrck;
    lrck_s2_d      = lrck_s1_q;
    data_s1_d      = i2s_data;
    data_s2_d      = data_s1_q;
    lr_last_d      = lr_last_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    have_left_d    = have_left_q;
    locked_d       = locked_q;
    left_hold_d    = left_hold_q;
    left_data_d    = left_data_q;
    right_data_d   = right_data_q;
    sample_valid_d = 1'b0;
    slot_err_d     = 1'b0;

    // Bits beyond DATA_W are dropped, so long slots keep only their top bits.
    word_next = shreg_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (int'(bit_cnt_q) == DATA_W - 1 - i) word_next[i] = data_s2_q;
    end
    bit_cnt_inc = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
    short_slot  = (int'(bit_cnt_q) + 1) < DATA_W;

    if (bck_rise) begin
      if (lrck_s2_q == lr_last_q) begin
        shreg_d   = word_next;
        bit_cnt_d = bit_cnt_inc;
      end else begin
        // One-bit I2S delay: this bit is the LSB of the slot that just ended.
        if (locked_q) begin
          if (!lr_last_q) begin
            left_hold_d = word_next;
            have_left_d = 1'b1;
          end else if (have_left_q) begin
            left_data_d    = left_hold_q;
            right_data_d   = word_next;
            sample_valid_d = 1'b1;
            have_left_d    = 1'b0;
          end
          slot_err_d = short_slot;
        end else begin
          locked_d = 1'b1;
        end
        shreg_d   = '0;
        bit_cnt_d = '0;
        lr_last_d = lrck_s2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      bck_s1_q       <= 1'b0;
      bck_s2_q       <= 1'b0;
      bck_s3_q       <= 1'b0;
      lrck_s1_q      <= 1'b0;
      lrck_s2_q      <= 1'b0;
      data_s1_q      <= 1'b0;
      data_s2_q      <= 1'b0;
      lr_last_q      <= 1'b0;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      have_left_q    <= 1'b0;
      locked_q       <= 1'b0;
      left_hold_q    <= '0;
      left_data_q    <= '0;
      right_data_q   <= '0;
      sample_valid_q <= 1'b0;
      slot_err_q     <= 1'b0;
    end else begin
      bck_s1_q       <= bck_s1_d;
      bck_s2_q       <= bck_s2_d;
      bck_s3_q       <= bck_s3_d;
      lrck_s1_q      <= lrck_s1_d;
      lrck_s2_q      <= lrck_s2_d;
      data_s1_q      <= data_s1_d;
      data_s2_q      <= data_s2_d;
      lr_last_q      <= lr_last_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      have_left_q    <= have_left_d;
      locked_q       <= locked_d;
      left_hold_q    <= left_hold_d;
      left_data_q    <= left_data_d;
      right_data_q   <= right_data_d;
      sample_valid_q <= sample_valid_d;
      slot_err_q     <= slot_err_d;
    end
  end

  assign left_data    = left_data_q;
  assign right_data   = right_data_q;
  assign sample_valid = sample_valid_q;
  assign slot_err     = slot_err_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: an I2S transmitter model pushes expected
// sample pairs to a scoreboard that is drained whenever sample_valid pulses.
module tb_i2s_rx;

  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              i2s_bck, i2s_lrck, i2s_data;
  logic [DATA_W-1:0] left_data, right_data;
  logic              sample_valid, slot_err, locked;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  pair_t exp_q[$];
  pair_t mon_e;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   valid_cnt;
  int   err_cnt;
  int   half_clks = 4;
  logic prev_lsb;

  i2s_rx #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .i2s_bck     (i2s_bck),
    .i2s_lrck    (i2s_lrck),
    .i2s_data    (i2s_data),
    .left_data   (left_data),
    .right_data  (right_data),
    .sample_valid(sample_valid),
    .slot_err    (slot_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] justify(input logic [31:0] w, input int n);
    if (n >= DATA_W) return DATA_W'(w >> (n - DATA_W));
    else             return DATA_W'(w << (DATA_W - n));
  endfunction

  // Scoreboard drain: every valid pulse must match the oldest expected pair.
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(sample_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("left_data", 64'(left_data), 64'(mon_e.l));
          check("right_data", 64'(right_data), 64'(mon_e.r));
        end
      end
      if (slot_err) err_cnt++;
    end
  end

  // One bit-clock period: lrck/data change with the falling edge, receiver samples on the rise.
  task automatic bck_period(input logic lr, input logic d);
    i2s_bck  = 1'b0;
    i2s_lrck = lr;
    i2s_data = d;
    repeat (half_clks) @(negedge clk);
    i2s_bck = 1'b1;
    repeat (half_clks) @(negedge clk);
  endtask

  // Periods [from, upto) of an n-bit slot; period 0 carries the previous slot's LSB.
  task automatic send_bits(input logic ch, input logic [31:0] w, input int n,
                           input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      bck_period(ch, (i == 0) ? prev_lsb : w[n-i]);
    end
    if (upto == n) prev_lsb = w[0];
  endtask

  task automatic send_slot(input logic ch, input logic [31:0] w, input int n);
    send_bits(ch, w, n, 0, n);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                            input bit expect_pair);
    pair_t p;
    if (expect_pair) begin
      p.l = justify(l, n);
      p.r = justify(r, n);
      exp_q.push_back(p);
    end
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
  endtask

  // A final word-select edge closes the last right slot.
  task automatic close_stream();
    bck_period(1'b0, prev_lsb);
    i2s_bck = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst      = 1'b1;
    i2s_bck  = 1'b0;
    i2s_lrck = 1'b0;
    i2s_data = 1'b0;
    prev_lsb = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_left"}, 64'(left_data), 64'(0));
    check({tag, "_right"}, 64'(right_data), 64'(0));
    check({tag, "_valid"}, 64'(sample_valid), 64'(0));
    check({tag, "_err"}, 64'(slot_err), 64'(0));
    check({tag, "_locked"}, 64'(locked), 64'(0));
  endtask

  task automatic begin_test(input int half);
    half_clks = half;
    apply_reset(2);
    rst = 1'b0;
    valid_cnt = 0;
    err_cnt   = 0;
    exp_q.delete();
  endtask

  task automatic end_test(input string tag, input int exp_valid, input int exp_err);
    check({tag, "_valid_count"}, 64'(valid_cnt), 64'(exp_valid));
    check({tag, "_err_count"}, 64'(err_cnt), 64'(exp_err));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] a, b;
    logic [DATA_W-1:0] hold_l, hold_r;
    int hold_v, hold_e;

    rst = 1'b1;
    i2s_bck = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0; prev_lsb = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");

    // 1: 32-bit slots at 8x oversampling.
    begin_test(4);
    send_frame(32'h12345600, 32'hABCDEF00, 32, 1'b0);
    check("t1_locked", 64'(locked), 64'(1));
    send_frame(32'h12345600, 32'hABCDEF00, 32, 1'b1);
    send_frame(32'h12345600, 32'hABCDEF00, 32, 1'b1);
    close_stream();
    end_test("t1", 2, 0);

    // 2: 16-bit slots are left-justified and flagged short.
    begin_test(4);
    for (int f = 0; f < 3; f++) send_frame(32'h0000BEEF, 32'h00008001, 16, f > 0);
    close_stream();
    end_test("t2", 2, 5);

    // 3: stream starts mid-right-slot; only full pairs come out.
    begin_test(4);
    send_bits(1'b1, 32'h00A5C3F0, 24, 14, 24);
    check("t3_locked", 64'(locked), 64'(1));
    send_frame(32'h00654321, 32'h00FEDCBA, 24, 1'b1);
    send_frame(32'h00010203, 32'h00F0E0D0, 24, 1'b1);
    close_stream();
    end_test("t3", 2, 1);

    // 4: reset pulse mid-left-slot, then re-lock.
    begin_test(4);
    send_frame(32'h00111111, 32'h00222222, 24, 1'b0);
    send_frame(32'h00333333, 32'h00444444, 24, 1'b1);
    send_bits(1'b0, 32'h00555555, 24, 0, 12);
    repeat (6) @(negedge clk);
    check("t4_pre_locked", 64'(locked), 64'(1));
    check("t4_pre_left", 64'(left_data), 64'h333333);
    apply_reset(2);
    check_zero_outputs("t4_in_reset");
    rst = 1'b0;
    send_bits(1'b0, 32'h00555555, 24, 12, 24);
    check("t4_unlocked", 64'(locked), 64'(0));
    send_slot(1'b1, 32'h00666666, 24);
    send_frame(32'h007FFFFF, 32'h00800000, 24, 1'b1);
    send_frame(32'h007FFFFF, 32'h00800000, 24, 1'b1);
    close_stream();
    end_test("t4", 3, 0);

    // 5: bck stalls mid-slot for 1000 clk cycles.
    begin_test(4);
    send_frame(32'h00ABCDEF, 32'h00123456, 24, 1'b0);
    send_frame(32'h00C0FFEE, 32'h00DEC0DE, 24, 1'b1);
    send_bits(1'b0, 32'h00135791, 24, 0, 10);
    repeat (6) @(negedge clk);
    hold_l = left_data; hold_r = right_data; hold_v = valid_cnt; hold_e = err_cnt;
    check("t5_before_stall_left", 64'(hold_l), 64'h00C0FFEE);
    repeat (1000) @(negedge clk);
    check("t5_stall_left", 64'(left_data), 64'(hold_l));
    check("t5_stall_right", 64'(right_data), 64'(hold_r));
    check("t5_stall_valids", 64'(valid_cnt), 64'(hold_v));
    check("t5_stall_errs", 64'(err_cnt), 64'(hold_e));
    begin
      pair_t p;
      p.l = 24'h135791;
      p.r = 24'h2468AC;
      exp_q.push_back(p);
    end
    send_bits(1'b0, 32'h00135791, 24, 10, 24);
    send_slot(1'b1, 32'h002468AC, 24);
    close_stream();
    end_test("t5", 2, 0);

    // 6: back-to-back random frames at 6x oversampling.
    begin_test(3);
    send_frame(32'h0, 32'h0, 24, 1'b0);
    for (int f = 0; f < 200; f++) begin
      a = $urandom & 32'h00FFFFFF;
      b = $urandom & 32'h00FFFFFF;
      send_frame(a, b, 24, 1'b1);
    end
    close_stream();
    end_test("t6", 200, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
